glb_stream_ingress: RTL and testbench

Synthesizable ingress stage that takes the 17-bit ready/valid token stream driven by the GLB write port and feeds it into the sparse fabric. It buffers tokens in a small first-word-fall-through FIFO and classifies each one as data, stop or done. It closes its input after a done token and reports end of stream once that token has drained. Status counters are provided for the test harness.

---
 rtl/sparse_stream_pkg.sv | 22 ++
 rtl/stream_fifo.sv | 56 +++++
 rtl/glb_stream_ingress.sv | 101 ++++++++++
 tb/tb_glb_stream_ingress.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_stream_pkg.sv
// Shared token definitions for the sparse stream path: widths, token classes,
// ingress states and the token classifier.
package sparse_stream_pkg;

  localparam int unsigned TOKEN_WIDTH = 17;
  localparam int unsigned CTRL_BIT    = 16;
  localparam logic [1:0]  DONE_CODE   = 2'b01;

  typedef enum logic [1:0] {DATA, STOP, DONE} token_class_t;
  typedef enum logic [1:0] {OPEN, CLOSED, DRAINED} ingress_state_t;

  // Control tokens carry their sub-code in bits [9:8].
  function automatic token_class_t classify_token(input logic [TOKEN_WIDTH-1:0] tok);
    if (!tok[CTRL_BIT])
      return DATA;
    else if (tok[9:8] == DONE_CODE)
      return DONE;
    else
      return STOP;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO; head word is combinational and reads as zero when empty.
module stream_fifo #(
  parameter int unsigned DATA_WIDTH = 17,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/glb_stream_ingress.sv
// GLB write-port ingress: buffers tokens, closes input after a done token and
// flags end of stream once it drains; keeps status counters for the harness.
module glb_stream_ingress
  import sparse_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 17,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  data_count,
  output logic [CNT_WIDTH-1:0]  stop_count,
  output logic                  err_after_done
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]  count;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  token_class_t   in_cls;
  token_class_t   out_cls;
  ingress_state_t st;
  ingress_state_t st_next;

  assign in_cls  = classify_token(in_data);
  assign out_cls = classify_token(out_data);
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  // Ready comes from registered state only, keeping the GLB handshake loop-free.
  assign in_ready  = (st == OPEN) && !full;
  assign out_valid = (st != DRAINED) && !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign done      = (st == DRAINED);

  stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (out_data),
    .count   (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= OPEN;
    else     st <= st_next;
  end

  always_comb begin
    st_next = st;
    if (flush)
      st_next = OPEN;
    else begin
      unique case (st)
        OPEN:    if (push && in_cls == DONE)  st_next = CLOSED;
        CLOSED:  if (pop && out_cls == DONE)  st_next = DRAINED;
        DRAINED: st_next = DRAINED;
        default: st_next = OPEN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_count     <= '0;
      stop_count     <= '0;
      err_after_done <= 1'b0;
    end else if (flush) begin
      data_count     <= '0;
      stop_count     <= '0;
      err_after_done <= 1'b0;
    end else begin
      if (pop && out_cls == DATA && data_count != '1)
        data_count <= data_count + 1'b1;
      if (pop && out_cls == STOP && stop_count != '1)
        stop_count <= stop_count + 1'b1;
      if (st != OPEN && in_valid)
        err_after_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_glb_stream_ingress.sv
// Bench for glb_stream_ingress: directed scenarios plus a randomized stream,
// all checked against a queue-based model of the ingress behaviour.
module tb_glb_stream_ingress;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [16:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic [15:0] data_count;
  logic [15:0] stop_count;
  logic        err_after_done;

  glb_stream_ingress #(
    .DATA_WIDTH (17),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .done           (done),
    .data_count     (data_count),
    .stop_count     (stop_count),
    .err_after_done (err_after_done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [16:0] m_q[$];
  bit          m_closed;
  bit          m_drained;
  int unsigned m_data;
  int unsigned m_stop;
  bit          m_err;
  logic [16:0] in_log[$];
  logic [16:0] out_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_closed  = 0;
    m_drained = 0;
    m_data    = 0;
    m_stop    = 0;
    m_err     = 0;
  endtask

  // 0 = data, 1 = stop, 2 = done
  function automatic int tok_kind(input logic [16:0] t);
    int unsigned v = t;
    if (((v >> 16) & 1) == 0) return 0;
    if (((v >> 8) & 3) == 1)  return 2;
    return 1;
  endfunction

  task automatic check_outputs(input string tag);
    logic [16:0] exp_head;
    exp_head = (m_q.size() > 0) ? m_q[0] : 17'h0;
    check({tag, ".in_ready"},  32'(in_ready),  32'(!m_closed && m_q.size() < DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() > 0 && !m_drained));
    check({tag, ".out_data"},  32'(out_data),  32'(exp_head));
    check({tag, ".done"},      32'(done),      32'(m_drained));
    check({tag, ".data_cnt"},  32'(data_count), m_data & 32'hFFFF);
    check({tag, ".stop_cnt"},  32'(stop_count), m_stop & 32'hFFFF);
    check({tag, ".err"},       32'(err_after_done), 32'(m_err));
  endtask

  // Drive one cycle, compare mid-cycle, then advance the model across the edge.
  task automatic cycle(input logic iv, input logic [16:0] id, input logic ordy,
                       input logic fl, output bit acc);
    bit p_push, p_pop;
    logic [16:0] t;
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    @(negedge clk);
    check_outputs("cyc");
    p_push = iv && !m_closed && m_q.size() < DEPTH;
    p_pop  = m_q.size() > 0 && !m_drained && ordy;
    acc = p_push && !fl;
    if (fl) model_reset();
    else begin
      if (iv && m_closed) m_err = 1;
      if (p_pop) begin
        out_log.push_back(out_data);
        t = m_q.pop_front();
        case (tok_kind(t))
          0: if (m_data < 32'hFFFF) m_data++;
          1: if (m_stop < 32'hFFFF) m_stop++;
          default: m_drained = 1;
        endcase
      end
      if (p_push) begin
        m_q.push_back(id);
        in_log.push_back(id);
        if (tok_kind(id) == 2) m_closed = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  // Offer a token until accepted, bounded by a cycle budget.
  task automatic send(input logic [16:0] tok, input int unsigned stall_pct);
    bit acc = 0;
    int unsigned budget = 200;
    while (!acc && budget > 0) begin
      if ($urandom_range(99) < stall_pct)
        cycle(1'b0, 17'h0, ($urandom_range(99) >= stall_pct), 1'b0, acc);
      else
        cycle(1'b1, tok, ($urandom_range(99) >= stall_pct), 1'b0, acc);
      budget--;
    end
    check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int unsigned n, input logic ordy);
    bit acc;
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 17'h0, ordy, 1'b0, acc);
  endtask

  task automatic compare_logs(input string tag);
    check({tag, ".len"}, out_log.size(), in_log.size());
    for (int i = 0; i < in_log.size() && i < out_log.size(); i++)
      if (out_log[i] !== in_log[i]) check({tag, ".tok"}, 32'(out_log[i]), 32'(in_log[i]));
    in_log.delete();
    out_log.delete();
  endtask

  initial begin
    bit acc;
    logic [16:0] tok;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #12;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Three data tokens at full rate
    cycle(1'b1, 17'h00005, 1'b1, 1'b0, acc);
    cycle(1'b1, 17'h00006, 1'b1, 1'b0, acc);
    cycle(1'b1, 17'h00007, 1'b1, 1'b0, acc);
    idle(2, 1'b1);
    check("t1.data_count", 32'(data_count), 32'd3);
    compare_logs("t1");

    // Fill with the consumer stalled, then release
    for (int unsigned i = 0; i < 4; i++) cycle(1'b1, 17'h00100 + 17'(i), 1'b0, 1'b0, acc);
    check("t2.full_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 17'h00104, 1'b0, 1'b0, acc);
    check("t2.refused", 32'(acc), 32'd0);
    send(17'h00104, 0);
    send(17'h00105, 0);
    idle(6, 1'b1);
    check("t2.data_count", 32'(data_count), 32'd9);
    compare_logs("t2");

    // Stop/done sequence after a flush
    cycle(1'b0, 17'h0, 1'b0, 1'b1, acc);
    send(17'h00001, 0);
    send(17'h10000, 0);
    send(17'h00002, 0);
    send(17'h10100, 0);
    check("t3.closed_ready", 32'(in_ready), 32'd0);
    idle(4, 1'b1);
    check("t3.done", 32'(done), 32'd1);
    check("t3.stop_count", 32'(stop_count), 32'd1);
    check("t3.data_count", 32'(data_count), 32'd2);
    compare_logs("t3");

    // Input after done, then flush back to reset state
    cycle(1'b1, 17'h00055, 1'b1, 1'b0, acc);
    check("t4.no_push", 32'(acc), 32'd0);
    check("t4.err", 32'(err_after_done), 32'd1);
    cycle(1'b0, 17'h0, 1'b0, 1'b1, acc);
    check("t4.in_ready", 32'(in_ready), 32'd1);
    check("t4.done", 32'(done), 32'd0);
    check("t4.err_clr", 32'(err_after_done), 32'd0);
    check("t4.cnt_clr", 32'({data_count, stop_count}), 32'd0);
    in_log.delete(); out_log.delete();

    // Randomized stream with 25% stalls on both sides
    for (int unsigned n = 0; n < 2048; n++) begin
      tok = 17'($urandom);
      if (tok_kind(tok) == 2) tok[8] = 1'b0;
      send(tok, 25);
    end
    idle(DEPTH + 8, 1'b1);
    compare_logs("rand");
    send(17'h10100, 25);
    idle(DEPTH + 8, 1'b1);
    check("rand.done", 32'(done), 32'd1);

    // Asynchronous reset with tokens buffered
    cycle(1'b0, 17'h0, 1'b0, 1'b1, acc);
    cycle(1'b1, 17'h00aa, 1'b0, 1'b0, acc);
    cycle(1'b1, 17'h00bb, 1'b0, 1'b0, acc);
    check("ar.pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar.out_valid", 32'(out_valid), 32'd0);
    check("ar.count", 32'(dut.u_fifo.count), 32'd0);
    check("ar.out_data", 32'(out_data), 32'd0);
    check("ar.in_ready", 32'(in_ready), 32'd1);
    model_reset();
    in_valid = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    idle(2, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
